// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    localparam int DATA_W = 8;
    localparam int DEF_CLKS_PER_BIT = 434;
endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO; head entry is visible on dout without a pop.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the head slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign dout    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead byte FIFO, with sticky framing/overrun flags.
//
// state | meaning
// IDLE  | line idle, waiting for rx_s low
// START | half-bit wait, then confirm start bit (reject glitch)
// DATA  | sample 8 data bits at mid-bit, LSB first
// STOP  | sample stop bit; push byte or flag framing error
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic              uldrxdata,
    input  logic              errclr,
    output logic [DATA_W-1:0] rxdata,
    output logic              rxempty,
    output logic              rxfull,
    output logic              ferr,
    output logic              overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t         state_q, state_d;
    logic              rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
    logic [CW-1:0]     baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              push_q, push_d;
    logic              ferr_q, ferr_d;
    logic              overrun_q, overrun_d;
    logic              rx_s, ferr_set, drop;

    assign rx_s = rx_s2_q;

    always_comb begin
        rx_s1_d   = rx;
        rx_s2_d   = rx_s1_q;
        state_d   = state_q;
        baud_d    = baud_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push_d    = 1'b0;
        ferr_set  = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d    = '0;
                bit_idx_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (baud_q == HALF_LAST) begin
                    baud_d  = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d            = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                    else                   bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d   = '0;
                    state_d  = IDLE;
                    push_d   = rx_s;
                    ferr_set = !rx_s;
                end
            end
            default: state_d = IDLE;
        endcase
        // Set events take priority over a same-cycle clear.
        ferr_d    = ferr_set ? 1'b1 : (errclr ? 1'b0 : ferr_q);
        overrun_d = drop     ? 1'b1 : (errclr ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            push_q    <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_s1_q   <= rx_s1_d;
            rx_s2_q   <= rx_s2_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            push_q    <= push_d;
            ferr_q    <= ferr_d;
            overrun_q <= overrun_d;
        end
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_q),
        .pop   (uldrxdata),
        .din   (shift_q),
        .dout  (rxdata),
        .empty (rxempty),
        .full  (rxfull),
        .drop  (drop)
    );

    assign ferr    = ferr_q;
    assign overrun = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks per bit and a 4-entry FIFO.
module tb_uart_rx_fifo;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       uldrxdata = 1'b0;
    logic       errclr = 1'b0;
    logic [7:0] rxdata;
    logic       rxempty, rxfull, ferr, overrun;
    int         checks = 0;
    int         errors = 0;
    int         fne;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .uldrxdata (uldrxdata),
        .errclr    (errclr),
        .rxdata    (rxdata),
        .rxempty   (rxempty),
        .rxfull    (rxfull),
        .ferr      (ferr),
        .overrun   (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Iteration c drives the line for posedge c+1; pop_at/rst_at pick a cycle for a
    // pop pulse or a reset abort (-1 = none). first_ne = first c seeing rxempty low.
    task automatic send(input logic [7:0] b, input logic stop_bit, input int pop_at,
                        input int rst_at, output int first_ne);
        int slot;
        first_ne = -1;
        for (int c = 0; c < 10 * CPB; c++) begin
            @(negedge clk);
            if (!rxempty && first_ne < 0) first_ne = c;
            if (c == rst_at) begin
                reset = 1'b1;
                rx    = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            slot      = c / CPB;
            rx        = (slot == 0) ? 1'b0 : (slot <= 8) ? b[slot-1] : stop_bit;
            uldrxdata = (c == pop_at);
        end
        @(negedge clk);
        rx        = 1'b1;
        uldrxdata = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic pop1();
        @(negedge clk);
        uldrxdata = 1'b1;
        @(negedge clk);
        uldrxdata = 1'b0;
    endtask

    task automatic clr1();
        @(negedge clk);
        errclr = 1'b1;
        @(negedge clk);
        errclr = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rxempty", rxempty, 1);
        chk("rst_rxdata", rxdata, 0);
        chk("rst_rxfull", rxfull, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_overrun", overrun, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        send(8'hA5, 1'b1, -1, -1, fne);
        chk("a5_latency", fne, 156);
        chk("a5_data", rxdata, 8'hA5);
        chk("a5_empty", rxempty, 0);
        chk("a5_ferr", ferr, 0);
        pop1();
        chk("a5_pop_empty", rxempty, 1);
        chk("a5_pop_data", rxdata, 0);
        pop1();
        chk("pop_on_empty", rxempty, 1);
        chk("pop_on_empty_ovr", overrun, 0);

        for (int i = 0; i < 4; i++) send(8'h31 + 8'(i), 1'b1, -1, -1, fne);
        chk("fill_full", rxfull, 1);
        chk("fill_no_ovr", overrun, 0);
        send(8'h35, 1'b1, -1, -1, fne);
        chk("ovr_set", overrun, 1);
        chk("ovr_full", rxfull, 1);
        for (int i = 0; i < 4; i++) begin
            chk("ovr_pop_data", rxdata, 8'h31 + 8'(i));
            pop1();
        end
        chk("ovr_drained", rxempty, 1);
        clr1();
        chk("ovr_clr", overrun, 0);

        send(8'h0F, 1'b0, -1, -1, fne);
        chk("ferr_set", ferr, 1);
        chk("ferr_no_push", rxempty, 1);
        clr1();
        chk("ferr_clr", ferr, 0);

        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_empty", rxempty, 1);
        chk("glitch_ferr", ferr, 0);
        chk("glitch_ovr", overrun, 0);
        send(8'h5A, 1'b1, -1, -1, fne);
        chk("post_glitch_data", rxdata, 8'h5A);
        pop1();
        chk("post_glitch_empty", rxempty, 1);

        for (int i = 0; i < 4; i++) send(8'h41 + 8'(i), 1'b1, -1, -1, fne);
        chk("pp_full_before", rxfull, 1);
        send(8'hEE, 1'b1, 155, -1, fne);
        chk("pp_no_ovr", overrun, 0);
        chk("pp_full_after", rxfull, 1);
        chk("pp_head", rxdata, 8'h42);
        pop1();
        chk("pp_2", rxdata, 8'h43);
        pop1();
        chk("pp_3", rxdata, 8'h44);
        pop1();
        chk("pp_4", rxdata, 8'hEE);
        pop1();
        chk("pp_empty", rxempty, 1);

        send(8'h0F, 1'b0, -1, -1, fne);
        send(8'h61, 1'b1, -1, -1, fne);
        send(8'h62, 1'b1, -1, -1, fne);
        chk("pre_rst_ferr", ferr, 1);
        chk("pre_rst_head", rxdata, 8'h61);
        send(8'hC3, 1'b1, -1, 60, fne);
        chk("mid_rst_empty", rxempty, 1);
        chk("mid_rst_data", rxdata, 0);
        chk("mid_rst_full", rxfull, 0);
        chk("mid_rst_ferr", ferr, 0);
        chk("mid_rst_ovr", overrun, 0);
        repeat (10) @(negedge clk);
        send(8'hC3, 1'b1, -1, -1, fne);
        chk("post_rst_data", rxdata, 8'hC3);
        chk("post_rst_ferr", ferr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
